// File: rtl/simplebus_pkg.sv
// Types and constants shared by the simplebus request queue and its FIFO.
// The 24-bit address is carried on the bus one byte at a time, upper byte first.
package simplebus_pkg;

  localparam int ADDR_W       = 24;
  localparam int DATA_W       = 8;
  localparam int ADDR_BYTE_W  = 8;
  localparam int ADDR_UP_LSB  = 16;
  localparam int ADDR_MID_LSB = 8;
  localparam int ADDR_LO_LSB  = 0;

  typedef enum logic [2:0] {
    IDLE,
    ADDR_UP,
    ADDR_MID,
    ADDR_LO,
    RD_WAIT,
    WR_DATA,
    RESP
  } bus_state_e;

  typedef struct packed {
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } req_entry_t;

endpackage

// File: rtl/simplebus_fifo.sv
// Synchronous request FIFO with a combinational head view so the consumer can
// pop and use the head entry in the same cycle.
module simplebus_fifo
  import simplebus_pkg::*;
#(
  parameter int  DEPTH   = 4,
  parameter type entry_t = req_entry_t
) (
  input  logic   clk_i,
  input  logic   srst_i,
  input  logic   push_i,
  input  entry_t entry_i,
  input  logic   pop_i,
  output entry_t entry_o,
  output logic   full_o,
  output logic   empty_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  entry_t           mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign entry_o = mem_q[rd_ptr_q];

  // Storage carries no reset; only the pointers and count define validity.
  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= entry_i;
    end
  end

  // DEPTH is a power of two, so the pointers wrap by plain overflow.
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/simplebus_req_queue.sv
// Queues simplebus requests and plays them out one at a time on the byte-wide
// bus, returning one registered response per request.
module simplebus_req_queue
  import simplebus_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_write,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              start,
  output logic              read,
  output logic [7:0]        address,
  output logic [DATA_W-1:0] data_o,
  output logic              data_oe,
  input  logic [DATA_W-1:0] data_i,
  output logic              dataValid_o,
  output logic              dataValid_oe,
  input  logic              dataValid_i
);

  localparam int                WAIT_W    = $clog2(TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  bus_state_e        state_q, state_d;
  req_entry_t        txn_q, txn_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_write_q, rsp_write_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;

  req_entry_t        push_entry;
  req_entry_t        head_entry;
  logic              fifo_full;
  logic              fifo_empty;
  logic              fifo_pop;

  assign req_ready  = !fifo_full;
  assign push_entry = '{write: req_write, addr: req_addr, wdata: req_wdata};

  simplebus_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (req_entry_t)
  ) u_fifo (
    .clk_i   (clock),
    .srst_i  (reset),
    .push_i  (req_valid && req_ready),
    .entry_i (push_entry),
    .pop_i   (fifo_pop),
    .entry_o (head_entry),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      txn_q       <= '0;
      wait_q      <= '0;
      rsp_valid_q <= 1'b0;
      rsp_write_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      txn_q       <= txn_d;
      wait_q      <= wait_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_write_q <= rsp_write_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    txn_d        = txn_q;
    wait_d       = '0;
    rsp_valid_d  = rsp_valid_q;
    rsp_write_d  = rsp_write_q;
    rsp_rdata_d  = rsp_rdata_q;
    rsp_err_d    = rsp_err_q;
    fifo_pop     = 1'b0;
    start        = 1'b0;
    read         = 1'b0;
    address      = '0;
    data_o       = '0;
    data_oe      = 1'b0;
    dataValid_o  = 1'b0;
    dataValid_oe = 1'b0;

    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          txn_d    = head_entry;
          state_d  = ADDR_UP;
        end
      end
      ADDR_UP: begin
        start   = 1'b1;
        address = txn_q.addr[ADDR_UP_LSB +: ADDR_BYTE_W];
        state_d = ADDR_MID;
      end
      ADDR_MID: begin
        address = txn_q.addr[ADDR_MID_LSB +: ADDR_BYTE_W];
        state_d = ADDR_LO;
      end
      ADDR_LO: begin
        address = txn_q.addr[ADDR_LO_LSB +: ADDR_BYTE_W];
        read    = !txn_q.write;
        state_d = txn_q.write ? WR_DATA : RD_WAIT;
      end
      WR_DATA: begin
        data_oe      = 1'b1;
        data_o       = txn_q.wdata;
        dataValid_oe = 1'b1;
        dataValid_o  = 1'b1;
        rsp_valid_d  = 1'b1;
        rsp_write_d  = 1'b1;
        rsp_rdata_d  = '0;
        rsp_err_d    = 1'b0;
        state_d      = RESP;
      end
      RD_WAIT: begin
        wait_d = wait_q + WAIT_W'(1);
        // Data arriving in the final wait cycle still counts as success.
        if (dataValid_i) begin
          rsp_valid_d = 1'b1;
          rsp_write_d = 1'b0;
          rsp_rdata_d = data_i;
          rsp_err_d   = 1'b0;
          state_d     = RESP;
        end else if (wait_q == WAIT_LAST) begin
          rsp_valid_d = 1'b1;
          rsp_write_d = 1'b0;
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b1;
          state_d     = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_write = rsp_write_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_simplebus_req_queue.sv
// Self-checking bench for simplebus_req_queue: directed corner cases followed by
// randomized traffic, all judged against a transaction-level model.
module tb_simplebus_req_queue;

  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 16;

  logic        clock;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [23:0] req_addr;
  logic [7:0]  req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_write;
  logic [7:0]  rsp_rdata;
  logic        rsp_err;
  logic        start;
  logic        read;
  logic [7:0]  address;
  logic [7:0]  data_o;
  logic        data_oe;
  logic [7:0]  data_i;
  logic        dataValid_o;
  logic        dataValid_oe;
  logic        dataValid_i;

  simplebus_req_queue #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clock        (clock),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_write    (req_write),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_write    (rsp_write),
    .rsp_rdata    (rsp_rdata),
    .rsp_err      (rsp_err),
    .start        (start),
    .read         (read),
    .address      (address),
    .data_o       (data_o),
    .data_oe      (data_oe),
    .data_i       (data_i),
    .dataValid_o  (dataValid_o),
    .dataValid_oe (dataValid_oe),
    .dataValid_i  (dataValid_i)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // dly: RD_WAIT cycle (1-based) in which the follower answers; 0 = never.
  typedef struct {
    logic        w;
    logic [23:0] a;
    logic [7:0]  wd;
    int          dly;
    logic [7:0]  rd;
  } txn_t;

  typedef struct {
    logic       w;
    logic [7:0] rd;
    logic       err;
  } rsp_t;

  txn_t bus_q[$];
  rsp_t exp_q[$];
  txn_t cur;
  rsp_t er;
  int   checks = 0;
  int   errors = 0;
  int   step;
  int   k;
  int   rdy_mode;
  logic mon_en;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit answered(input int dly);
    return (dly >= 1) && (dly <= TIMEOUT);
  endfunction

  // Called just after a falling edge; returns just after a falling edge.
  task automatic push(input logic w, input logic [23:0] a, input logic [7:0] wd,
                      input int dly, input logic [7:0] rd, output int waited);
    txn_t t;
    rsp_t r;
    logic acc;
    t = '{w, a, wd, dly, rd};
    req_valid = 1'b1;
    req_write = w;
    req_addr  = a;
    req_wdata = wd;
    waited    = 0;
    acc       = 1'b0;
    while (!acc && waited < 300) begin
      acc = req_ready;
      @(posedge clock);
      if (!acc) begin
        waited++;
        @(negedge clock);
      end
    end
    if (acc) begin
      bus_q.push_back(t);
      r.w   = w;
      r.rd  = (!w && answered(dly)) ? rd : 8'h00;
      r.err = !w && !answered(dly);
      exp_q.push_back(r);
      @(negedge clock);
    end else begin
      check("push_accept", 32'(acc), 32'd1);
    end
    req_valid = 1'b0;
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clock);
      n++;
    end
    check("drain_empty", exp_q.size(), 0);
    repeat (3) @(negedge clock);
  endtask

  task automatic measure(output int to_start, output int to_rsp);
    to_start = 0;
    while (!start && to_start < 50) begin
      @(negedge clock);
      to_start++;
    end
    to_rsp = 0;
    while (!rsp_valid && to_rsp < 50) begin
      @(negedge clock);
      to_rsp++;
    end
  endtask

  // rsp_ready changes just after the rising edge so it is stable when sampled.
  initial begin
    rsp_ready = 1'b0;
    forever begin
      @(posedge clock);
      #1;
      case (rdy_mode)
        0:       rsp_ready = 1'b0;
        1:       rsp_ready = 1'b1;
        default: rsp_ready = ($urandom_range(0, 2) != 0);
      endcase
    end
  end

  // Bus monitor and read follower: checks the byte sequence of each transaction.
  initial begin
    dataValid_i = 1'b0;
    data_i      = 8'h00;
    step        = 0;
    k           = 0;
    forever begin
      @(negedge clock);
      if (!mon_en) begin
        step        = 0;
        dataValid_i = 1'b0;
      end else begin
        if (!data_oe)      check("data_o_gated", data_o, 0);
        if (!dataValid_oe) check("dv_o_gated", dataValid_o, 0);
        case (step)
          0: begin
            dataValid_i = 1'b0;
            data_i      = 8'($urandom);
            if (start) begin
              check("bus_pending", 32'(bus_q.size() != 0), 1);
              if (bus_q.size() != 0) begin
                cur = bus_q.pop_front();
                check("addr_up", address, cur.a[23:16]);
                check("read_up", read, 0);
                step = 1;
              end
            end else begin
              check("idle_outputs", {read, address, data_oe, dataValid_oe}, 0);
            end
          end
          1: begin
            check("addr_mid", {start, read, address}, {2'b00, cur.a[15:8]});
            step = 2;
          end
          2: begin
            check("addr_lo", {start, read, address}, {1'b0, !cur.w, cur.a[7:0]});
            k    = 0;
            step = cur.w ? 3 : 4;
          end
          3: begin
            check("wr_data", {data_oe, dataValid_oe, dataValid_o, data_o},
                  {3'b111, cur.wd});
            check("wr_addr", {start, read, address}, 0);
            step = 0;
          end
          default: begin
            if (rsp_valid) begin
              check("rd_wait_len", k, answered(cur.dly) ? cur.dly : TIMEOUT);
              dataValid_i = 1'b0;
              step        = 0;
            end else begin
              k++;
              check("rd_wait_outputs", {start, read, address, data_oe, dataValid_oe}, 0);
              if (k == cur.dly) begin
                dataValid_i = 1'b1;
                data_i      = cur.rd;
              end else begin
                dataValid_i = 1'b0;
                data_i      = 8'($urandom);
              end
              if (k > TIMEOUT + 4) begin
                check("rd_wait_bound", k, TIMEOUT);
                step = 0;
              end
            end
          end
        endcase
      end
    end
  end

  // Response monitor: one line per completed transaction.
  initial begin
    forever begin
      @(negedge clock);
      if (mon_en) begin
        if (rsp_valid) check("no_start_in_resp", start, 0);
        if (rsp_valid && rsp_ready) begin
          check("rsp_expected", 32'(exp_q.size() != 0), 1);
          if (exp_q.size() != 0) begin
            er = exp_q.pop_front();
            check("rsp_write", rsp_write, er.w);
            check("rsp_rdata", rsp_rdata, er.rd);
            check("rsp_err", rsp_err, er.err);
            $display("rsp write=%0d rdata=0x%02h err=%0d", rsp_write, rsp_rdata, rsp_err);
          end
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int waited;
    int ts;
    int tr;
    int quiet_bad;
    logic        w;
    logic [23:0] a;
    logic [7:0]  wd;
    logic [7:0]  rd;
    int          dly;

    reset     = 1'b1;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    mon_en    = 1'b0;
    rdy_mode  = 1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst_req_ready", req_ready, 1);
    check("rst_rsp", {rsp_valid, rsp_write, rsp_err, rsp_rdata}, 0);
    check("rst_bus", {start, read, address, data_o, data_oe, dataValid_o, dataValid_oe}, 0);
    reset = 1'b0;
    @(negedge clock);
    mon_en = 1'b1;

    // Write 0x010406 / 0xDC: one IDLE cycle, then 4 cycles to RESP.
    push(1'b1, 24'h010406, 8'hDC, 0, 8'h00, waited);
    measure(ts, tr);
    check("wr_to_start", ts, 1);
    check("wr_to_rsp", tr, 4);
    drain(100);

    // Read answered after 3 wait cycles, then timeout, then data on the last cycle.
    push(1'b0, 24'h010407, 8'h00, 3, 8'hAB, waited);
    measure(ts, tr);
    check("rd3_to_rsp", tr, 6);
    drain(100);
    push(1'b0, 24'h0A0B0C, 8'h00, 0, 8'h00, waited);
    measure(ts, tr);
    check("rd_timeout_to_rsp", tr, 3 + TIMEOUT);
    drain(100);
    push(1'b0, 24'h0D0E0F, 8'h00, TIMEOUT, 8'h5A, waited);
    measure(ts, tr);
    check("rd_last_to_rsp", tr, 3 + TIMEOUT);
    drain(100);
    push(1'b0, 24'h112233, 8'h00, TIMEOUT + 1, 8'hC3, waited);
    drain(100);

    // Back-to-back pushes with responses blocked: 5 fit, the 6th must stall.
    rdy_mode = 0;
    repeat (3) @(negedge clock);
    for (int i = 0; i < 5; i++) begin
      push(1'b1, 24'h300000 + 24'(i), 8'h30 + 8'(i), 0, 8'h00, waited);
      check("b2b_accept_wait", waited, 0);
    end
    check("ready_when_full", req_ready, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check("stall_6th", req_ready, 0);
    end
    rdy_mode = 1;
    push(1'b1, 24'h300005, 8'h35, 0, 8'h00, waited);
    drain(500);

    // Reset in ADDR_MID with two requests still queued.
    push(1'b1, 24'hA1A2A3, 8'h11, 0, 8'h00, waited);
    push(1'b1, 24'hB1B2B3, 8'h22, 0, 8'h00, waited);
    push(1'b0, 24'hC1C2C3, 8'h00, 2, 8'h33, waited);
    check("pre_reset_mid", {start, address}, {1'b0, 8'hA2});
    mon_en = 1'b0;
    reset  = 1'b1;
    @(negedge clock);
    check("mid_rst_bus", {start, read, address, data_o, data_oe, dataValid_o, dataValid_oe}, 0);
    check("mid_rst_ready", req_ready, 1);
    check("mid_rst_rsp_valid", rsp_valid, 0);
    reset = 1'b0;
    bus_q.delete();
    exp_q.delete();
    quiet_bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (rsp_valid || start) quiet_bad++;
    end
    check("post_reset_quiet", quiet_bad, 0);
    mon_en = 1'b1;
    push(1'b1, 24'hD1D2D3, 8'h44, 0, 8'h00, waited);
    drain(100);

    // Randomized traffic with random response back-pressure.
    rdy_mode = 2;
    for (int i = 0; i < 40; i++) begin
      w  = 1'($urandom_range(0, 1));
      a  = 24'($urandom);
      wd = 8'($urandom);
      rd = 8'($urandom);
      case ($urandom_range(0, 5))
        0:       dly = 0;
        1:       dly = TIMEOUT;
        2:       dly = TIMEOUT + 1;
        default: dly = $urandom_range(1, 8);
      endcase
      push(w, a, wd, w ? 0 : dly, rd, waited);
      repeat ($urandom_range(0, 3)) @(negedge clock);
    end
    drain(4000);
    check("bus_queue_empty", bus_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
